regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with same-cycle write bypass and a per-register pending (scoreboard) bit. It replaces the fixed 2-read/1-write 64-bit register file in the core. It serves issue logic that needs more read ports, more than one writeback port and operand-readiness tracking. Register 0 is hardwired to zero and never pending.

## Interface
Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; power of two, ≥ 2.
- NR, 2, number of read ports (1–4).
- NW, 1, number of write ports (1–3).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads; when 0 reads see the stored value only.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NR*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NR*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rd_pend  out  NR  1 = register addressed by port k has an outstanding producer.
- wr_en  in  NW  write enable per write port.
- wr_addr  in  NW*AW  write addresses.
- wr_data  in  NW*XLEN  write data.
- alloc_en  in  1  mark alloc_addr pending (new producer issued).
- alloc_addr  in  AW  register to mark pending.
- pend_cnt  out  AW+1  registered count of pending registers.

## Operation
- Storage: NREGS × XLEN array plus NREGS pending bits. Entry 0 is never written. pend[0] is constant 0.
- Write, rising edge: for each register r ≠ 0, if any port j has wr_en[j] && wr_addr[j]==r, then reg[r] ← wr_data of the highest-index such j. Lower-index colliding writes are dropped silently.
- Read, combinational, for each port k:
  - rd_addr==0 → rd_data 0, rd_pend 0.
  - BYPASS=1 and a write hits rd_addr this cycle → rd_data = the winning wr_data, rd_pend 0.
  - Otherwise → rd_data = reg[rd_addr], rd_pend = pend[rd_addr].
- Pending update, rising edge, per register r ≠ 0:
  - set if alloc_en && alloc_addr==r;
  - else cleared if any write hits r;
  - else held.
  - Alloc and write to the same r in one cycle: alloc wins. pend stays/becomes 1 (a new producer supersedes the one completing). The data is still written.
- alloc_addr==0 is ignored.
- Writes to a register that is not pending are legal. They update data and leave pend at 0.
- pend_cnt: register, next value = popcount of the next pending vector. Range 0..NREGS-1; never wraps.

## Timing
- Reset, asynchronous on rst_n low: all reg = 0, all pend = 0, pend_cnt = 0. rd_data = 0 and rd_pend = 0 for every address while in reset.
- Reset deasserts synchronously to clk (external synchroniser). The first edge after release performs normal updates.
- Reset asserted mid-cycle discards that cycle's writes and allocs.
- Read latency 0 (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- alloc → rd_pend visible 1 cycle later. Write → pend cleared 1 cycle later; with BYPASS=1, rd_pend drops the same cycle.
- pend_cnt lags pending state by 0 cycles: it is registered alongside it.
- No combinational path from alloc_* to any output.

## Test plan
- Reset with x5 pre-written to 0xDEAD: assert rst_n=0 asynchronously mid-cycle → rd_data 0 immediately, pend_cnt 0, and x5 reads 0 after release.
- Write x0 = 0xFFFF_FFFF_FFFF_FFFF and alloc x0 → rd_data(x0)=0, rd_pend 0, pend_cnt 0.
- NW=2, both ports write x7 (port0 = 0x11, port1 = 0x22) → x7 reads 0x22 next cycle. With BYPASS=1, a same-cycle read of x7 returns 0x22.
- alloc x3, x4, x9 on consecutive cycles → pend_cnt 1, 2, 3. Write x4 → rd_pend(x4)=0 same cycle (BYPASS=1), and pend_cnt = 2 after the edge.
- Same cycle alloc x3 and write x3 = 0xABCD while x3 is pending → x3 = 0xABCD, rd_pend(x3) stays 1, pend_cnt unchanged.
- BYPASS=0, write x10 = 0x55 with a same-cycle read of x10 → old value returned that cycle, 0x55 the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass and
// a per-register pending (scoreboard) bit. x0 reads zero and is never pending.
module regfile_mp #(
   parameter int XLEN   = 64,
   parameter int NREGS  = 32,
   parameter int NR     = 2,
   parameter int NW     = 1,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NR*AW-1:0]     rd_addr_i,
   output logic [NR*XLEN-1:0]   rd_data_o,
   output logic [NR-1:0]        rd_pend_o,
   input  logic [NW-1:0]        wr_en_i,
   input  logic [NW*AW-1:0]     wr_addr_i,
   input  logic [NW*XLEN-1:0]   wr_data_i,
   input  logic                 alloc_en_i,
   input  logic [AW-1:0]        alloc_addr_i,
   output logic [AW:0]          pend_cnt_o
);

   logic [NREGS-1:0][XLEN-1:0] regs_q;
   logic [NREGS-1:0]           pend_q, pend_d;
   logic [AW:0]                pend_cnt_q, pend_cnt_d;

   // Per-register write hit and winning data; higher port index overrides lower.
   logic [NREGS-1:0]           whit;
   logic [NREGS-1:0][XLEN-1:0] wval;

   // Resolve write-port collisions into one hit/value per register
   always_comb begin
      whit = '0;
      wval = '0;
      for (int j = 0; j < NW; j++) begin
         if (wr_en_i[j]) begin
            whit[wr_addr_i[j*AW +: AW]] = 1'b1;
            wval[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
         end
      end
      // x0 is hardwired; a write to it is never a hit
      whit[0] = 1'b0;
      wval[0] = '0;
   end

   // Data storage: winning writes land on the rising edge
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         regs_q <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (whit[r]) regs_q[r] <= wval[r];
         end
      end
   end

   // Next pending vector: alloc beats a completing write on the same register
   always_comb begin
      pend_d     = pend_q;
      pend_cnt_d = '0;
      pend_d[0]  = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         if (alloc_en_i && alloc_addr_i == AW'(r)) pend_d[r] = 1'b1;
         else if (whit[r])                          pend_d[r] = 1'b0;
      end
      for (int r = 0; r < NREGS; r++) begin
         pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[r]};
      end
   end

   // Pending bits and their population count register together
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend_cnt_o = pend_cnt_q;

   // Read ports: purely combinational, forced to zero while reset is held
   for (genvar k = 0; k < NR; k++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            p;

      assign a = rd_addr_i[k*AW +: AW];

      // Select bypass, stored value or zero for this port
      always_comb begin
         d = '0;
         p = 1'b0;
         if (rst_n_i && a != '0) begin
            if (BYPASS != 0 && whit[a]) begin
               d = wval[a];
            end else begin
               d = regs_q[a];
               p = pend_q[a];
            end
         end
      end

      assign rd_data_o[k*XLEN +: XLEN] = d;
      assign rd_pend_o[k]              = p;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed table, reset corner, then random traffic
// against an array-based model. Two instances share stimulus: bypass on/off.
module tb_regfile_mp;
   localparam int XLEN = 64, NREGS = 32, NR = 3, NW = 2, AW = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [AW-1:0]     ra [NR];
   logic [NW-1:0]     we;
   logic [AW-1:0]     wa [NW];
   logic [XLEN-1:0]   wd [NW];
   logic              ae;
   logic [AW-1:0]     aa;

   logic [NR*AW-1:0]   rd_addr;
   logic [NW*AW-1:0]   wr_addr;
   logic [NW*XLEN-1:0] wr_data;
   logic [NR*XLEN-1:0] rdd_b, rdd_n;
   logic [NR-1:0]      rdp_b, rdp_n;
   logic [AW:0]        cnt_b, cnt_n;

   assign rd_addr = {ra[2], ra[1], ra[0]};
   assign wr_addr = {wa[1], wa[0]};
   assign wr_data = {wd[1], wd[0]};

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW), .BYPASS(1)) u_b (
      .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdd_b),
      .rd_pend_o(rdp_b), .wr_en_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .alloc_en_i(ae), .alloc_addr_i(aa), .pend_cnt_o(cnt_b));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW), .BYPASS(0)) u_n (
      .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdd_n),
      .rd_pend_o(rdp_n), .wr_en_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .alloc_en_i(ae), .alloc_addr_i(aa), .pend_cnt_o(cnt_n));

   int checks = 0;
   int errors = 0;

   // Reference state: architectural values and outstanding-producer flags
   logic [XLEN-1:0] mem [NREGS];
   bit              pend [NREGS];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) begin
         mem[r]  = '0;
         pend[r] = 1'b0;
      end
   endtask

   function automatic int model_cnt();
      int c = 0;
      for (int r = 0; r < NREGS; r++) c += pend[r];
      return c;
   endfunction

   // Expected read: x0 is zero, a live write wins when forwarding, else stored state
   task automatic exp_read(input int a, input bit byp, output logic [XLEN-1:0] d, output bit p);
      bit              hit = 0;
      logic [XLEN-1:0] v = '0;
      for (int j = 0; j < NW; j++)
         if (we[j] && int'(wa[j]) == a) begin hit = 1; v = wd[j]; end
      if (a == 0)          begin d = '0;     p = 0;       end
      else if (byp && hit) begin d = v;      p = 0;       end
      else                 begin d = mem[a]; p = pend[a]; end
   endtask

   // Edge update: later ports overwrite earlier ones, alloc applied last so it wins
   task automatic model_edge();
      for (int j = 0; j < NW; j++)
         if (we[j] && wa[j] != 0) begin mem[wa[j]] = wd[j]; pend[wa[j]] = 1'b0; end
      if (ae && aa != 0) pend[aa] = 1'b1;
   endtask

   task automatic idle();
      we = '0; ae = 1'b0; aa = '0;
      for (int j = 0; j < NW; j++) begin wa[j] = '0; wd[j] = '0; end
      for (int k = 0; k < NR; k++) ra[k] = '0;
   endtask

   // Check every read port of both instances against the model
   task automatic check_reads();
      logic [XLEN-1:0] d;
      bit              p;
      for (int k = 0; k < NR; k++) begin
         exp_read(int'(ra[k]), 1'b1, d, p);
         chk($sformatf("byp_data%0d", k), rdd_b[k*XLEN +: XLEN], d);
         chk($sformatf("byp_pend%0d", k), {63'd0, rdp_b[k]}, {63'd0, p});
         exp_read(int'(ra[k]), 1'b0, d, p);
         chk($sformatf("nob_data%0d", k), rdd_n[k*XLEN +: XLEN], d);
         chk($sformatf("nob_pend%0d", k), {63'd0, rdp_n[k]}, {63'd0, p});
      end
   endtask

   typedef struct {
      logic [1:0]      we;
      logic [AW-1:0]   wa0, wa1;
      logic [XLEN-1:0] wd0, wd1;
      logic            ae;
      logic [AW-1:0]   aa;
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] ed_b;
      logic            ep_b;
      logic [XLEN-1:0] ed_n;
      logic            ep_n;
      int              ecnt;
   } vec_t;

   vec_t tbl [13];

   initial begin
      // {we, wa0, wa1, wd0, wd1, ae, aa, ra, byp data, byp pend, nob data, nob pend, cnt after edge}
      tbl[0]  = '{2'b01, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 5'd0, 5'd0, 64'd0,      1'b0, 64'd0,      1'b0, 0};
      tbl[1]  = '{2'b11, 5'd7, 5'd7, 64'h11,   64'h22,   1'b0, 5'd0, 5'd7, 64'h22,     1'b0, 64'd0,      1'b0, 0};
      tbl[2]  = '{2'b00, 5'd0, 5'd0, 64'd0,    64'd0,    1'b0, 5'd0, 5'd7, 64'h22,     1'b0, 64'h22,     1'b0, 0};
      tbl[3]  = '{2'b00, 5'd0, 5'd0, 64'd0,    64'd0,    1'b1, 5'd3, 5'd3, 64'd0,      1'b0, 64'd0,      1'b0, 1};
      tbl[4]  = '{2'b00, 5'd0, 5'd0, 64'd0,    64'd0,    1'b1, 5'd4, 5'd3, 64'd0,      1'b1, 64'd0,      1'b1, 2};
      tbl[5]  = '{2'b00, 5'd0, 5'd0, 64'd0,    64'd0,    1'b1, 5'd9, 5'd4, 64'd0,      1'b1, 64'd0,      1'b1, 3};
      tbl[6]  = '{2'b01, 5'd4, 5'd0, 64'h44,   64'd0,    1'b0, 5'd0, 5'd4, 64'h44,     1'b0, 64'd0,      1'b1, 2};
      tbl[7]  = '{2'b10, 5'd0, 5'd3, 64'd0,    64'hABCD, 1'b1, 5'd3, 5'd3, 64'hABCD,   1'b0, 64'd0,      1'b1, 2};
      tbl[8]  = '{2'b00, 5'd0, 5'd0, 64'd0,    64'd0,    1'b0, 5'd0, 5'd3, 64'hABCD,   1'b1, 64'hABCD,   1'b1, 2};
      tbl[9]  = '{2'b11, 5'd9, 5'd5, 64'h99,   64'hDEAD, 1'b0, 5'd0, 5'd9, 64'h99,     1'b0, 64'd0,      1'b1, 1};
      tbl[10] = '{2'b00, 5'd0, 5'd0, 64'd0,    64'd0,    1'b0, 5'd0, 5'd5, 64'hDEAD,   1'b0, 64'hDEAD,   1'b0, 1};
      tbl[11] = '{2'b01, 5'd10, 5'd0, 64'h55,  64'd0,    1'b0, 5'd0, 5'd10, 64'h55,    1'b0, 64'd0,      1'b0, 1};
      tbl[12] = '{2'b00, 5'd0, 5'd0, 64'd0,    64'd0,    1'b0, 5'd0, 5'd10, 64'h55,    1'b0, 64'h55,     1'b0, 1};

      idle();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cnt_b", {58'd0, cnt_b}, 64'd0);
      chk("rst_cnt_n", {58'd0, cnt_n}, 64'd0);
      check_reads();
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table, one cycle per row; model tracks along for the random phase
      for (int i = 0; i < 13; i++) begin
         idle();
         we = tbl[i].we; wa[0] = tbl[i].wa0; wa[1] = tbl[i].wa1;
         wd[0] = tbl[i].wd0; wd[1] = tbl[i].wd1;
         ae = tbl[i].ae; aa = tbl[i].aa; ra[0] = tbl[i].ra;
         #1;
         chk($sformatf("row%0d_byp_data", i), rdd_b[XLEN-1:0], tbl[i].ed_b);
         chk($sformatf("row%0d_byp_pend", i), {63'd0, rdp_b[0]}, {63'd0, tbl[i].ep_b});
         chk($sformatf("row%0d_nob_data", i), rdd_n[XLEN-1:0], tbl[i].ed_n);
         chk($sformatf("row%0d_nob_pend", i), {63'd0, rdp_n[0]}, {63'd0, tbl[i].ep_n});
         @(posedge clk);
         model_edge();
         @(negedge clk);
         chk($sformatf("row%0d_cnt", i), {58'd0, cnt_b}, 64'(tbl[i].ecnt));
         chk($sformatf("row%0d_cnt_n", i), {58'd0, cnt_n}, 64'(tbl[i].ecnt));
      end

      // Asynchronous reset mid-cycle while a write to x5 and an alloc are live
      idle();
      we = 2'b01; wa[0] = 5'd5; wd[0] = 64'h1234; ae = 1'b1; aa = 5'd6; ra[0] = 5'd5; ra[1] = 5'd3;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_byp_x5", rdd_b[XLEN-1:0], 64'd0);
      chk("midrst_nob_x5", rdd_n[XLEN-1:0], 64'd0);
      chk("midrst_pend_x3", {63'd0, rdp_b[1]}, 64'd0);
      chk("midrst_cnt", {58'd0, cnt_b}, 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      ra[0] = 5'd5; ra[1] = 5'd6; ra[2] = 5'd3;
      #1;
      chk("post_rst_x5", rdd_b[XLEN-1:0], 64'd0);
      chk("post_rst_x5_n", rdd_n[XLEN-1:0], 64'd0);
      chk("post_rst_pend_x6", {63'd0, rdp_b[1]}, 64'd0);
      chk("post_rst_cnt", {58'd0, cnt_b}, 64'd0);
      @(negedge clk);

      // Random traffic, biased toward a few registers to force collisions
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < NW; j++) begin
            we[j] = ($urandom_range(0, 2) != 0);
            wa[j] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            wd[j] = {$urandom, $urandom};
         end
         ae = ($urandom_range(0, 1) != 0);
         aa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
         for (int k = 0; k < NR; k++)
            ra[k] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
         #1;
         check_reads();
         @(posedge clk);
         model_edge();
         @(negedge clk);
         chk("rnd_cnt_b", {58'd0, cnt_b}, 64'(model_cnt()));
         chk("rnd_cnt_n", {58'd0, cnt_n}, 64'(model_cnt()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
